// File: rtl/fpu_result_collector.sv
// Result collector behind FPU_Control: acknowledges each DOV/DOA handshake once,
// queues {EXC, DOUT} in a show-ahead FIFO, and keeps sticky exception/stuck flags.
module fpu_result_collector #(
    parameter int DEPTH        = 4,
    parameter int AW           = 2,
    parameter int DROP_TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [31:0]   DOUT_IN,
    input  logic          DOV_IN,
    input  logic [2:0]    EXC_IN,
    output logic          DOA_OUT,
    input  logic          RD_EN,
    output logic [31:0]   RD_DATA,
    output logic [2:0]    RD_EXC,
    output logic          EMPTY,
    output logic          FULL,
    output logic [AW:0]   COUNT,
    output logic [2:0]    EXC_ACC,
    output logic          STUCK_ERR,
    input  logic          CLR_ERR,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK       = 2'd1,
        WAIT_DROP = 2'd2
    } state_t;

    localparam logic [7:0]  TIMEOUT_LIM = 8'(DROP_TIMEOUT);
    localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(DEPTH);

    state_t         state_q, state_d;
    logic           doa_q, doa_d;
    logic [7:0]     tcnt_q, tcnt_d;
    logic           stuck_q, stuck_d;
    logic [2:0]     exc_acc_q, exc_acc_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [34:0]    mem_q [DEPTH];
    logic [34:0]    mem_d [DEPTH];

    logic           full;
    logic           empty;
    logic           capture;
    logic           pop;
    logic [7:0]     tcnt_inc;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    // Write decision uses this cycle's FULL, so a coincident pop never frees a slot early.
    assign capture = (state_q == IDLE) && DOV_IN && !full;
    assign pop     = RD_EN && !empty;
    assign tcnt_inc = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        doa_d     = 1'b0;
        tcnt_d    = tcnt_q;
        stuck_d   = CLR_ERR ? 1'b0 : stuck_q;
        exc_acc_d = CLR_ERR ? 3'b000 : exc_acc_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d   = ACK;
                    doa_d     = 1'b1;
                    exc_acc_d = exc_acc_d | EXC_IN;
                end
            end
            ACK: begin
                state_d = WAIT_DROP;
                tcnt_d  = 8'd0;
            end
            WAIT_DROP: begin
                if (!DOV_IN) begin
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_inc;
                    // Setting wins over a same-cycle CLR_ERR.
                    if (tcnt_inc >= TIMEOUT_LIM) begin
                        stuck_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (capture) begin
            mem_d[wr_ptr_q] = {EXC_IN, DOUT_IN};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (capture && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !capture) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            doa_q     <= 1'b0;
            tcnt_q    <= 8'd0;
            stuck_q   <= 1'b0;
            exc_acc_q <= 3'b000;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            doa_q     <= doa_d;
            tcnt_q    <= tcnt_d;
            stuck_q   <= stuck_d;
            exc_acc_q <= exc_acc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign DOA_OUT   = doa_q;
    assign RD_DATA   = empty ? 32'd0 : mem_q[rd_ptr_q][31:0];
    assign RD_EXC    = empty ? 3'd0  : mem_q[rd_ptr_q][34:32];
    assign EMPTY     = empty;
    assign FULL      = full;
    assign COUNT     = count_q;
    assign EXC_ACC   = exc_acc_q;
    assign STUCK_ERR = stuck_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector: handshake timing, FIFO ordering,
// backpressure, sticky flags, stuck detection and mid-handshake reset.
module tb_fpu_result_collector;

  logic        clk;
  logic        rst_n;
  logic [31:0] dout_in;
  logic        dov_in;
  logic [2:0]  exc_in;
  logic        doa_out;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [2:0]  rd_exc;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic [2:0]  exc_acc;
  logic        stuck_err;
  logic        clr_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  fpu_result_collector #(.DEPTH(4), .AW(2), .DROP_TIMEOUT(15)) dut (
    .CLK(clk), .RSTn(rst_n), .DOUT_IN(dout_in), .DOV_IN(dov_in), .EXC_IN(exc_in),
    .DOA_OUT(doa_out), .RD_EN(rd_en), .RD_DATA(rd_data), .RD_EXC(rd_exc),
    .EMPTY(empty), .FULL(full), .COUNT(count), .EXC_ACC(exc_acc),
    .STUCK_ERR(stuck_err), .CLR_ERR(clr_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full three-cycle handshake for one result with DOV dropped right after capture.
  task automatic send(input logic [31:0] d, input logic [2:0] e);
    dov_in  = 1'b1;
    dout_in = d;
    exc_in  = e;
    tick();
    chk("send_doa", {31'd0, doa_out}, 32'd1);
    dov_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d, input logic [2:0] e);
    chk({tag, "_data"}, rd_data, d);
    chk({tag, "_exc"}, {29'd0, rd_exc}, {29'd0, e});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_vals [4];
    rst_n = 1'b0; dout_in = '0; dov_in = 1'b0; exc_in = '0; rd_en = 1'b0; clr_err = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_doa", {31'd0, doa_out}, 32'd0);
    chk("rst_exc_acc", {29'd0, exc_acc}, 32'd0);
    chk("rst_stuck", {31'd0, stuck_err}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);

    // Single result, DOV held 3 cycles
    dov_in = 1'b1; dout_in = 32'h3F800000; exc_in = 3'b000;
    tick();
    chk("t1_doa_hi", {31'd0, doa_out}, 32'd1);
    chk("t1_count", {29'd0, count}, 32'd1);
    chk("t1_rd_data", rd_data, 32'h3F800000);
    chk("t1_rd_exc", {29'd0, rd_exc}, 32'd0);
    chk("t1_empty", {31'd0, empty}, 32'd0);
    tick();
    chk("t1_doa_lo", {31'd0, doa_out}, 32'd0);
    chk("t1_state_wait", {30'd0, state_dbg}, 32'd2);
    tick();
    chk("t1_doa_lo2", {31'd0, doa_out}, 32'd0);
    chk("t1_count_held", {29'd0, count}, 32'd1);
    dov_in = 1'b0;
    tick();
    chk("t1_state_idle", {30'd0, state_dbg}, 32'd0);
    pop_expect("t1_pop", 32'h3F800000, 3'b000);
    chk("t1_empty_after", {31'd0, empty}, 32'd1);

    // Fill to FULL, then backpressure
    for (int i = 1; i <= 4; i++) send(32'(i), 3'b000);
    chk("t2_count4", {29'd0, count}, 32'd4);
    chk("t2_full", {31'd0, full}, 32'd1);
    dov_in = 1'b1; dout_in = 32'h00000005; exc_in = 3'b000;
    tick();
    chk("t2_bp_doa", {31'd0, doa_out}, 32'd0);
    chk("t2_bp_state", {30'd0, state_dbg}, 32'd0);
    tick();
    chk("t2_bp_doa2", {31'd0, doa_out}, 32'd0);
    chk("t2_bp_count", {29'd0, count}, 32'd4);
    chk("t2_head", rd_data, 32'h00000001);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t2_pop_count", {29'd0, count}, 32'd3);
    chk("t2_pop_nodoa", {31'd0, doa_out}, 32'd0);
    tick();
    chk("t2_fifth_doa", {31'd0, doa_out}, 32'd1);
    chk("t2_fifth_count", {29'd0, count}, 32'd4);
    dov_in = 1'b0;
    tick();
    tick();
    exp_vals[0] = 32'h2; exp_vals[1] = 32'h3; exp_vals[2] = 32'h4; exp_vals[3] = 32'h5;
    for (int i = 0; i < 4; i++) pop_expect("t2_drain", exp_vals[i], 3'b000);
    chk("t2_drained", {29'd0, count}, 32'd0);

    // Sticky exception accumulation and clear
    send(32'hAAAA0001, 3'b010);
    send(32'hAAAA0002, 3'b100);
    chk("t3_acc", {29'd0, exc_acc}, 32'd6);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t3_acc_clr", {29'd0, exc_acc}, 32'd0);
    pop_expect("t3_e1", 32'hAAAA0001, 3'b010);
    pop_expect("t3_e2", 32'hAAAA0002, 3'b100);
    send(32'hAAAA0003, 3'b100);
    chk("t3_acc_pre", {29'd0, exc_acc}, 32'd4);
    clr_err = 1'b1; dov_in = 1'b1; dout_in = 32'hAAAA0004; exc_in = 3'b001;
    tick();
    clr_err = 1'b0; dov_in = 1'b0;
    chk("t3_clr_cap_acc", {29'd0, exc_acc}, 32'd1);
    tick();
    tick();
    pop_expect("t3_e3", 32'hAAAA0003, 3'b100);
    pop_expect("t3_e4", 32'hAAAA0004, 3'b001);

    // Stuck handshake; timeout edge coincides with CLR_ERR
    dov_in = 1'b1; dout_in = 32'h000000A5; exc_in = 3'b000;
    tick();
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk("t4_not_yet", {31'd0, stuck_err}, 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_stuck_set_wins", {31'd0, stuck_err}, 32'd1);
    chk("t4_state_wait", {30'd0, state_dbg}, 32'd2);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_single_cap", {29'd0, count}, 32'd1);
    chk("t4_doa_lo", {31'd0, doa_out}, 32'd0);
    dov_in = 1'b0;
    tick();
    chk("t4_idle", {30'd0, state_dbg}, 32'd0);
    chk("t4_still_stuck", {31'd0, stuck_err}, 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_clr", {31'd0, stuck_err}, 32'd0);
    pop_expect("t4_pop", 32'h000000A5, 3'b000);

    // Simultaneous write + pop, pop while empty
    send(32'hB0000001, 3'b000);
    send(32'hB0000002, 3'b000);
    dov_in = 1'b1; dout_in = 32'hB0000003; rd_en = 1'b1;
    tick();
    dov_in = 1'b0; rd_en = 1'b0;
    chk("t5_count_same", {29'd0, count}, 32'd2);
    chk("t5_head_adv", rd_data, 32'hB0000002);
    chk("t5_doa", {31'd0, doa_out}, 32'd1);
    tick();
    tick();
    pop_expect("t5_p1", 32'hB0000002, 3'b000);
    pop_expect("t5_p2", 32'hB0000003, 3'b000);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t5_empty_pop_cnt", {29'd0, count}, 32'd0);
    chk("t5_empty_flag", {31'd0, empty}, 32'd1);
    send(32'hB0000004, 3'b011);
    chk("t5_ptr_ok_cnt", {29'd0, count}, 32'd1);
    pop_expect("t5_after_empty", 32'hB0000004, 3'b011);

    // Reset during ACK with COUNT=3
    send(32'hC0000001, 3'b000);
    send(32'hC0000002, 3'b000);
    dov_in = 1'b1; dout_in = 32'hC0000003; exc_in = 3'b001;
    tick();
    chk("t6_ack_doa", {31'd0, doa_out}, 32'd1);
    chk("t6_count3", {29'd0, count}, 32'd3);
    rst_n = 1'b0; dov_in = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_doa", {31'd0, doa_out}, 32'd0);
    chk("t6_count", {29'd0, count}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_exc_acc", {29'd0, exc_acc}, 32'd0);
    chk("t6_state", {30'd0, state_dbg}, 32'd0);
    chk("t6_rd_data", rd_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_result_collector.md
Name: fpu_result_collector

Overview:
- Downstream stage of FPU_Control.
- Consumes the FPU result handshake (DOUT/DOV/DOA, with EXC) and acknowledges each result exactly once.
- Buffers each result with its exception code in a small show-ahead FIFO for the host.
- Flags a stuck handshake and accumulates sticky exception bits.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
AW, 2, log2(DEPTH)
DROP_TIMEOUT, 15, cycles DOV may stay high after DOA before STUCK_ERR sets; range 1..255

Ports:
CLK  input  1  clock; all state updates on the rising edge
RSTn  input  1  reset; synchronous, active-low
DOUT_IN  input  32  result word from FPU_Control DOUT
DOV_IN  input  1  result valid from FPU_Control DOV
EXC_IN  input  3  exception code from FPU_Control EXC, qualified by DOV_IN
DOA_OUT  output  1  result acknowledge to FPU_Control DOA; registered
RD_EN  input  1  host pop request
RD_DATA  output  32  head-of-FIFO result; show-ahead
RD_EXC  output  3  head-of-FIFO exception code
EMPTY  output  1  FIFO empty
FULL  output  1  FIFO full
COUNT  output  AW+1  FIFO occupancy, 0..DEPTH
EXC_ACC  output  3  sticky bitwise OR of every captured EXC
STUCK_ERR  output  1  sticky; DOV_IN did not drop within DROP_TIMEOUT after DOA
CLR_ERR  input  1  clears EXC_ACC and STUCK_ERR

Behaviour:
- Reset: synchronous, sampled on the rising edge when RSTn=0; overrides everything.
  - FIFO flushed: COUNT=0, EMPTY=1, FULL=0.
  - DOA_OUT=0, EXC_ACC=0, STUCK_ERR=0, FSM to IDLE, timeout counter cleared.
  - RD_DATA and RD_EXC read 0 while empty after reset.
  - Reset mid-handshake (ACK or WAIT_DROP) drops DOA_OUT on that edge and discards buffered data.
- FSM states: IDLE, ACK, WAIT_DROP.
- IDLE:
  - If DOV_IN=1 and FULL=0 at the edge: write {EXC_IN, DOUT_IN} at the tail, OR EXC_IN into EXC_ACC, go to ACK.
  - If DOV_IN=1 and FULL=1: no write, no ack; remain in IDLE, providing backpressure to the FPU.
- ACK:
  - DOA_OUT=1 for exactly one cycle, the cycle after capture.
  - Next edge: go to WAIT_DROP, DOA_OUT=0, timeout counter cleared.
- WAIT_DROP:
  - If DOV_IN=0: go to IDLE. A new result is only captured after DOV_IN is observed low, so a held DOV never double-captures.
  - If DOV_IN=1: increment the timeout counter, saturating. When it reaches DROP_TIMEOUT, set STUCK_ERR and stay in WAIT_DROP.
- Capture-to-ack latency: DOV_IN sampled high in IDLE at edge N gives DOA_OUT=1 during cycle N+1 and 0 from N+2.
- Minimum spacing: 3 cycles per result (IDLE capture, ACK, WAIT_DROP seeing DOV=0).
- FIFO:
  - Circular buffer with AW-bit read and write pointers; pointers wrap from DEPTH-1 to 0.
  - COUNT is tracked separately.
  - RD_DATA and RD_EXC present the head entry combinationally from registered storage.
  - Pop on an edge with RD_EN=1 and EMPTY=0; RD_EN while EMPTY is ignored, with no pointer or COUNT change.
  - Simultaneous write and pop: both occur, COUNT unchanged. Allowed at any COUNT where the write is permitted.
  - The write decision uses FULL from the current cycle; a same-cycle pop does not enable a write into a full FIFO.
- Sticky flags:
  - CLR_ERR=1 clears EXC_ACC and STUCK_ERR on the edge.
  - If a capture with nonzero EXC_IN coincides with CLR_ERR, the new EXC_IN bits win: EXC_ACC=EXC_IN.
  - If the timeout is reached in the same cycle as CLR_ERR, STUCK_ERR=1 (set wins).
- The timeout counter is 8 bits.

Test Plan:
- Reset, then DOV_IN=1 with DOUT_IN=32'h3F800000, EXC_IN=0, held 3 cycles then dropped -> DOA_OUT high exactly 1 cycle (the cycle after capture); COUNT=1; RD_DATA=32'h3F800000; RD_EXC=0; EMPTY=0.
- Four results 32'h00000001..32'h00000004 with no host reads -> COUNT=4, FULL=1. A 5th result with DOV_IN held -> no DOA_OUT, state stays IDLE. One RD_EN pop (RD_DATA=32'h00000001) -> 5th result captured on the following edge, DOA_OUT pulses.
- Result with EXC_IN=3'b010, then a result with EXC_IN=3'b100 -> EXC_ACC=3'b110. CLR_ERR pulse -> EXC_ACC=0; the FIFO entries still hold their RD_EXC values 3'b010, then 3'b100 after a pop.
- DOV_IN held high 20 cycles after DOA_OUT -> STUCK_ERR=1 after 15 WAIT_DROP cycles, a single capture only (COUNT=1). DOV_IN=0, then CLR_ERR -> STUCK_ERR=0, FSM back in IDLE.
- FIFO at COUNT=2, RD_EN=1 on the same edge as a capture -> COUNT stays 2, head advances. RD_EN while EMPTY=1 -> COUNT stays 0, no pointer change.
- RSTn=0 during the ACK cycle with COUNT=3 -> next cycle DOA_OUT=0, COUNT=0, EMPTY=1, EXC_ACC=0, FSM in IDLE.
